// File: rtl/button_pkg.sv
// Shared encodings and default timing for the pushbutton event chain.
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE  = 2'd0,
    BTN_PRESS = 2'd1,
    BTN_LONG  = 2'd2
  } btn_state_t;

  // 0.5 s to long-press and 0.1 s between repeats at a 100 MHz system clock.
  localparam int LONG_COUNT_100MHZ   = 50_000_000;
  localparam int REPEAT_COUNT_100MHZ = 10_000_000;
  localparam int BTN_CNT_W           = 26;

endpackage

// File: rtl/button_event_edge_detect.sv
// Registers the debounced level once and exposes its rising/falling edges.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic level_q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long-press/repeat pulses.
module button_event
  import button_pkg::*;
#(
  parameter int LONG_COUNT   = LONG_COUNT_100MHZ,
  parameter int REPEAT_COUNT = REPEAT_COUNT_100MHZ,
  parameter int CNT_W        = BTN_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  input  logic enable,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  btn_state_t state, next_state;
  logic [CNT_W-1:0] counter, counter_next;
  logic btn_q, rise, fall;
  logic long_hit, repeat_hit;
  logic press_next, release_next, long_next, repeat_next, held_next;

  edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .level   (btn_level),
    .level_q (btn_q),
    .rise    (rise),
    .fall    (fall)
  );

  assign long_hit   = (counter == CNT_W'(LONG_COUNT - 1));
  assign repeat_hit = (counter == CNT_W'(REPEAT_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BTN_IDLE;
      counter       <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= next_state;
      counter       <= counter_next;
      press         <= press_next;
      release_pulse <= release_next;
      long_press    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= held_next;
    end
  end

  // A fall always takes priority over a terminal count landing in the same cycle.
  always_comb begin
    next_state   = state;
    counter_next = counter;
    if (!enable) begin
      next_state   = BTN_IDLE;
      counter_next = '0;
    end else begin
      case (state)
        BTN_IDLE: begin
          counter_next = '0;
          if (rise) next_state = BTN_PRESS;
        end
        BTN_PRESS: begin
          if (fall) begin
            next_state   = BTN_IDLE;
            counter_next = '0;
          end else if (long_hit) begin
            next_state   = BTN_LONG;
            counter_next = '0;
          end else begin
            counter_next = counter + 1'b1;
          end
        end
        BTN_LONG: begin
          if (fall) begin
            next_state   = BTN_IDLE;
            counter_next = '0;
          end else if (repeat_hit) begin
            counter_next = '0;
          end else begin
            counter_next = counter + 1'b1;
          end
        end
        default: begin
          next_state   = BTN_IDLE;
          counter_next = '0;
        end
      endcase
    end
  end

  // Pulses are decoded here and registered above, so they land one cycle after the cause.
  always_comb begin
    press_next   = enable && (state == BTN_IDLE) && rise;
    release_next = enable && ((state == BTN_PRESS) || (state == BTN_LONG)) && fall;
    long_next    = enable && (state == BTN_PRESS) && !fall && long_hit;
    repeat_next  = enable && (state == BTN_LONG) && !fall && repeat_hit;
    held_next    = (next_state == BTN_PRESS) || (next_state == BTN_LONG);
  end

endmodule
